// File: rtl/wb_daq_arb_pkg.sv
// Shared state encoding, default parameters and helpers for the DAQ SRAM arbiter.
package wb_daq_arb_pkg;

    localparam int DEF_NUM_CHANNELS   = 4;
    localparam int DEF_DW             = 32;
    localparam int DEF_AW             = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RELEASE = 3'd4
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_daq_rr_picker.sv
// Combinational round-robin picker: first eligible channel strictly after last_grant,
// wrapping around, returned as a one-hot vector plus a valid flag.
module wb_daq_rr_picker
    import wb_daq_arb_pkg::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int IW           = idx_width(DEF_NUM_CHANNELS)
) (
    input  logic [NUM_CHANNELS-1:0] eligible,
    input  logic [IW-1:0]           last_grant,
    output logic [NUM_CHANNELS-1:0] pick,
    output logic                    valid
);

    // Two passes: channels above last_grant first, then the wrapped-around lower half.
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!valid && eligible[i] && (i > int'(last_grant))) begin
                pick[i] = 1'b1;
                valid   = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!valid && eligible[i] && (i <= int'(last_grant))) begin
                pick[i] = 1'b1;
                valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_daq_sram_arbiter.sv
// Round-robin arbiter sharing one SRAM write port between DAQ channels, with per-channel
// circular addressing. Optional WAIT watchdog enabled by WB_DAQ_ARB_TIMEOUT_EN.
module wb_daq_sram_arbiter
    import wb_daq_arb_pkg::*;
#(
    parameter int NUM_CHANNELS   = DEF_NUM_CHANNELS,
    parameter int dw             = DEF_DW,
    parameter int aw             = DEF_AW,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                       wb_clk,
    input  logic                       wb_rst,
    input  logic                       master_enable,
    input  logic [NUM_CHANNELS-1:0]    channel_enable,
    input  logic [NUM_CHANNELS-1:0]    request,
    input  logic [NUM_CHANNELS*dw-1:0] channel_data,
    input  logic [NUM_CHANNELS*aw-1:0] channel_base,
    input  logic [NUM_CHANNELS*aw-1:0] channel_length,
    input  logic                       sram_done,
    output logic [NUM_CHANNELS-1:0]    grant,
    output logic [NUM_CHANNELS-1:0]    data_done,
    output logic                       sram_start,
    output logic [dw-1:0]              sram_data,
    output logic [aw-1:0]              sram_address,
    output logic [NUM_CHANNELS-1:0]    wrapped,
    output logic                       busy
`ifdef WB_DAQ_ARB_TIMEOUT_EN
    ,
    output logic                       timeout_err
`endif
);

    localparam int IW = idx_width(NUM_CHANNELS);

    arb_state_e              state_q, state_d;
    logic [NUM_CHANNELS-1:0] grant_q, grant_d;
    logic [NUM_CHANNELS-1:0] data_done_q, data_done_d;
    logic [NUM_CHANNELS-1:0] wrapped_q, wrapped_d;
    logic [IW-1:0]           last_grant_q, last_grant_d;
    logic                    sram_start_q, sram_start_d;
    logic [dw-1:0]           sram_data_q, sram_data_d;
    logic [aw-1:0]           sram_address_q, sram_address_d;
    logic [aw-1:0]           offset_q [NUM_CHANNELS];
    logic [aw-1:0]           offset_d [NUM_CHANNELS];

    logic [dw-1:0]           data_arr [NUM_CHANNELS];
    logic [aw-1:0]           base_arr [NUM_CHANNELS];
    logic [aw-1:0]           len_arr  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] eligible;
    logic [NUM_CHANNELS-1:0] pick;
    logic                    pick_valid;
    logic [IW-1:0]           pick_idx;
    logic [aw-1:0]           last_offset;

`ifdef WB_DAQ_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_err_q, timeout_err_d;
    assign timeout_err = timeout_err_q;
`endif

    assign eligible = request & channel_enable & {NUM_CHANNELS{master_enable}};

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            data_arr[i] = channel_data[i*dw +: dw];
            base_arr[i] = channel_base[i*aw +: aw];
            len_arr[i]  = channel_length[i*aw +: aw];
            if (pick[i]) pick_idx = IW'(i);
        end
    end

    wb_daq_rr_picker #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .IW           (IW)
    ) u_picker (
        .eligible   (eligible),
        .last_grant (last_grant_q),
        .pick       (pick),
        .valid      (pick_valid)
    );

    // A zero length is treated as one, so that channel's offset stays pinned at 0.
    assign last_offset = (len_arr[last_grant_q] == '0) ? '0 : len_arr[last_grant_q] - 1'b1;

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        data_done_d    = '0;
        wrapped_d      = wrapped_q;
        sram_start_d   = 1'b0;
        sram_data_d    = sram_data_q;
        sram_address_d = sram_address_q;
        offset_d       = offset_q;
`ifdef WB_DAQ_ARB_TIMEOUT_EN
        tmo_cnt_d      = tmo_cnt_q;
        timeout_err_d  = timeout_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d      = pick;
                    last_grant_d = pick_idx;
                    state_d      = ST_GRANT;
                end
            end
            ST_GRANT: state_d = ST_START;
            ST_START: begin
                sram_start_d   = 1'b1;
                sram_data_d    = data_arr[last_grant_q];
                sram_address_d = base_arr[last_grant_q] + offset_q[last_grant_q];
                state_d        = ST_WAIT;
`ifdef WB_DAQ_ARB_TIMEOUT_EN
                tmo_cnt_d      = '0;
`endif
            end
            ST_WAIT: begin
                if (sram_done) begin
                    data_done_d = grant_q;
                    if (offset_q[last_grant_q] >= last_offset) begin
                        offset_d[last_grant_q]  = '0;
                        wrapped_d[last_grant_q] = 1'b1;
                    end else begin
                        offset_d[last_grant_q] = offset_q[last_grant_q] + 1'b1;
                    end
                    state_d = ST_RELEASE;
                end
`ifdef WB_DAQ_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_RELEASE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            ST_RELEASE: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q        <= ST_IDLE;
            grant_q        <= '0;
            last_grant_q   <= IW'(NUM_CHANNELS - 1);
            data_done_q    <= '0;
            wrapped_q      <= '0;
            sram_start_q   <= 1'b0;
            sram_data_q    <= '0;
            sram_address_q <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) offset_q[i] <= '0;
`ifdef WB_DAQ_ARB_TIMEOUT_EN
            tmo_cnt_q      <= '0;
            timeout_err_q  <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_grant_q   <= last_grant_d;
            data_done_q    <= data_done_d;
            wrapped_q      <= wrapped_d;
            sram_start_q   <= sram_start_d;
            sram_data_q    <= sram_data_d;
            sram_address_q <= sram_address_d;
            offset_q       <= offset_d;
`ifdef WB_DAQ_ARB_TIMEOUT_EN
            tmo_cnt_q      <= tmo_cnt_d;
            timeout_err_q  <= timeout_err_d;
`endif
        end
    end

    assign grant        = grant_q;
    assign data_done    = data_done_q;
    assign wrapped      = wrapped_q;
    assign sram_start   = sram_start_q;
    assign sram_data    = sram_data_q;
    assign sram_address = sram_address_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_daq_sram_arbiter.sv
// Testbench for wb_daq_sram_arbiter: directed and randomized transfers checked against a
// transfer-level round-robin / circular-buffer model. Optional WB_DAQ_ARB_TIMEOUT_EN section.
module tb_wb_daq_sram_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int TO = 16;

    logic            wb_clk = 1'b0;
    logic            wb_rst;
    logic            master_enable;
    logic [N-1:0]    channel_enable;
    logic [N-1:0]    request;
    logic [N*DW-1:0] channel_data;
    logic [N*AW-1:0] channel_base;
    logic [N*AW-1:0] channel_length;
    logic            sram_done;
    logic [N-1:0]    grant;
    logic [N-1:0]    data_done;
    logic            sram_start;
    logic [DW-1:0]   sram_data;
    logic [AW-1:0]   sram_address;
    logic [N-1:0]    wrapped;
    logic            busy;
`ifdef WB_DAQ_ARB_TIMEOUT_EN
    logic            timeout_err;
`endif

    always #5 wb_clk = ~wb_clk;

    wb_daq_sram_arbiter #(
        .NUM_CHANNELS   (N),
        .dw             (DW),
        .aw             (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk         (wb_clk),
        .wb_rst         (wb_rst),
        .master_enable  (master_enable),
        .channel_enable (channel_enable),
        .request        (request),
        .channel_data   (channel_data),
        .channel_base   (channel_base),
        .channel_length (channel_length),
        .sram_done      (sram_done),
        .grant          (grant),
        .data_done      (data_done),
        .sram_start     (sram_start),
        .sram_data      (sram_data),
        .sram_address   (sram_address),
        .wrapped        (wrapped),
        .busy           (busy)
`ifdef WB_DAQ_ARB_TIMEOUT_EN
        ,
        .timeout_err    (timeout_err)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;
    int modelOffset [N];
    bit modelWrapped [N];
    int modelLast;

    // Every comparison in the bench funnels through here so both counters stay honest.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] en, input logic me);
        request        = req;
        channel_enable = en;
        master_enable  = me;
    endtask

    // Reference arbitration: first eligible channel after the last winner, modulo N.
    function automatic int expectedWinner(input logic [N-1:0] elig, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (elig[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [63:0] wrapVec();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = modelWrapped[i];
        return v;
    endfunction

    task automatic modelReset();
        modelLast = N - 1;
        for (int i = 0; i < N; i++) begin
            modelOffset[i]  = 0;
            modelWrapped[i] = 1'b0;
        end
    endtask

    // One arbitration round starting from IDLE at a falling edge. Optionally fires sram_done
    // outside WAIT (must be ignored) and disturbs the inputs while the transfer is in flight.
    task automatic runTransfer(input int delay, input bit spurious, input bit scramble);
        logic [N-1:0]    elig, sReq, sEn;
        logic            sMe;
        logic [N*DW-1:0] sData;
        logic [DW-1:0]   expData;
        logic [AW-1:0]   expAddr;
        logic [63:0]     oneHot;
        int              w, len;
        sReq  = request;
        sEn   = channel_enable;
        sMe   = master_enable;
        sData = channel_data;
        elig  = request & channel_enable & {N{master_enable}};
        w     = expectedWinner(elig, modelLast);
        @(negedge wb_clk);
        if (w < 0) begin
            checkOutput("idle_grant", 64'(grant), 64'd0);
            checkOutput("idle_busy", 64'(busy), 64'd0);
            return;
        end
        modelLast = w;
        oneHot    = 64'd1 << w;
        expData   = channel_data[w*DW +: DW];
        expAddr   = AW'(int'(channel_base[w*AW +: AW]) + modelOffset[w]);
        checkOutput("grant", 64'(grant), oneHot);
        checkOutput("busy", 64'(busy), 64'd1);
        if (spurious) sram_done = 1'b1;
        @(negedge wb_clk);
        checkOutput("start_early", 64'(sram_start), 64'd0);
        @(negedge wb_clk);
        checkOutput("sram_start", 64'(sram_start), 64'd1);
        checkOutput("sram_data", 64'(sram_data), 64'(expData));
        checkOutput("sram_address", 64'(sram_address), 64'(expAddr));
        checkOutput("done_early", 64'(data_done), 64'd0);
        for (int d = 0; d < delay; d++) begin
            sram_done = 1'b0;
            if (scramble) begin
                request        = N'($urandom);
                channel_enable = N'($urandom);
                master_enable  = 1'b0;
                channel_data   = {4{$urandom}};
            end
            @(negedge wb_clk);
            checkOutput("wait_grant", 64'(grant), oneHot);
            checkOutput("wait_done", 64'(data_done), 64'd0);
            checkOutput("wait_start", 64'(sram_start), 64'd0);
            checkOutput("wait_data", 64'(sram_data), 64'(expData));
        end
        sram_done = 1'b1;
        @(negedge wb_clk);
        sram_done      = 1'b0;
        request        = sReq;
        channel_enable = sEn;
        master_enable  = sMe;
        channel_data   = sData;
        len = int'(channel_length[w*AW +: AW]);
        if (len == 0) len = 1;
        modelOffset[w] = (modelOffset[w] + 1) % len;
        if (modelOffset[w] == 0) modelWrapped[w] = 1'b1;
        checkOutput("data_done", 64'(data_done), oneHot);
        checkOutput("done_grant", 64'(grant), oneHot);
        @(negedge wb_clk);
        checkOutput("release_grant", 64'(grant), 64'd0);
        checkOutput("release_done", 64'(data_done), 64'd0);
        checkOutput("release_busy", 64'(busy), 64'd0);
        checkOutput("wrapped", 64'(wrapped), wrapVec());
    endtask

    initial begin
        int w;
        wb_rst         = 1'b1;
        sram_done      = 1'b0;
        applyStimulus('0, '0, 1'b0);
        channel_data   = '0;
        channel_base   = {16'hFFFF, 16'h0300, 16'h0200, 16'h0100};
        channel_length = {16'd2, 16'd0, 16'd3, 16'd4};
        modelReset();
        repeat (3) @(negedge wb_clk);
        checkOutput("rst_grant", 64'(grant), 64'd0);
        checkOutput("rst_start", 64'(sram_start), 64'd0);
        checkOutput("rst_addr", 64'(sram_address), 64'd0);
        checkOutput("rst_data", 64'(sram_data), 64'd0);
        checkOutput("rst_wrapped", 64'(wrapped), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        wb_rst = 1'b0;
        @(negedge wb_clk);

        $display("[TB] channel 0 alone: circular addresses 0x100..0x103 then wrap");
        applyStimulus(4'b0001, 4'b1111, 1'b1);
        for (int t = 0; t < 5; t++) begin
            channel_data[31:0] = $urandom;
            runTransfer(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] all channels requesting: round-robin rotation");
        channel_data = {32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000};
        applyStimulus(4'b1111, 4'b1111, 1'b1);
        for (int t = 0; t < 6; t++) runTransfer(int'($urandom_range(0, 2)), 1'b0, 1'b0);

        $display("[TB] disabled channel 2 must never win");
        applyStimulus(4'b1100, 4'b1011, 1'b1);
        for (int t = 0; t < 3; t++) runTransfer(1, 1'b0, 1'b0);
        applyStimulus(4'b0100, 4'b1011, 1'b1);
        runTransfer(0, 1'b0, 1'b0);

        $display("[TB] master_enable and requests dropped mid-transfer");
        applyStimulus(4'b1111, 4'b1111, 1'b1);
        runTransfer(3, 1'b1, 1'b1);
        runTransfer(2, 1'b0, 1'b1);
        applyStimulus(4'b1111, 4'b1111, 1'b0);
        runTransfer(0, 1'b0, 1'b0);
        runTransfer(0, 1'b0, 1'b0);

        $display("[TB] reset asserted while waiting for sram_done");
        applyStimulus(4'b0010, 4'b1111, 1'b1);
        repeat (3) @(negedge wb_clk);
        checkOutput("pre_rst_start", 64'(sram_start), 64'd1);
        #2 wb_rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            channel_base[i*AW +: AW]   = AW'($urandom);
            channel_length[i*AW +: AW] = AW'($urandom_range(0, 5));
        end
        #1;
        checkOutput("async_rst_grant", 64'(grant), 64'd0);
        checkOutput("async_rst_start", 64'(sram_start), 64'd0);
        checkOutput("async_rst_addr", 64'(sram_address), 64'd0);
        checkOutput("async_rst_data", 64'(sram_data), 64'd0);
        checkOutput("async_rst_wrapped", 64'(wrapped), 64'd0);
        checkOutput("async_rst_busy", 64'(busy), 64'd0);
        modelReset();
        @(negedge wb_clk);
        wb_rst = 1'b0;
        applyStimulus(4'b1111, 4'b1111, 1'b1);
        runTransfer(0, 1'b0, 1'b0);

        $display("[TB] randomized requests, enables and data");
        for (int t = 0; t < 40; t++) begin
            applyStimulus(N'($urandom), N'($urandom) | 4'b1001, 1'($urandom_range(0, 7) != 0));
            channel_data = {4{$urandom}};
            runTransfer(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

`ifdef WB_DAQ_ARB_TIMEOUT_EN
        $display("[TB] watchdog abort with no sram_done");
        applyStimulus(4'b0001, 4'b1111, 1'b1);
        w = expectedWinner(4'b0001, modelLast);
        modelLast = w;
        repeat (3) @(negedge wb_clk);
        checkOutput("to_start", 64'(sram_start), 64'd1);
        repeat (TO - 1) @(negedge wb_clk);
        checkOutput("to_pending", 64'(timeout_err), 64'd0);
        checkOutput("to_pending_grant", 64'(grant), 64'd1);
        @(negedge wb_clk);
        checkOutput("to_err", 64'(timeout_err), 64'd1);
        checkOutput("to_no_done", 64'(data_done), 64'd0);
        applyStimulus('0, 4'b1111, 1'b1);
        @(negedge wb_clk);
        checkOutput("to_release", 64'(grant), 64'd0);
        applyStimulus(4'b0001, 4'b1111, 1'b1);
        runTransfer(0, 1'b0, 1'b0);
        checkOutput("to_err_sticky", 64'(timeout_err), 64'd1);
`else
        w = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
